// File: rtl/instr_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch_if : program-load, run-control and issue handshake bus    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface instr_fetch_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        dip_in;
  logic              load_pulse;
  logic              run_pulse;
  logic              step_mode;
  logic              exec_ready;
  logic [7:0]        instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] load_addr;
  logic              halted;

  // master: the fetch unit
  modport master (
    input  dip_in, load_pulse, run_pulse, step_mode, exec_ready,
    output instr, instr_valid, pc, load_addr, halted
  );

  // slave: the control panel / execute stage side
  modport slave (
    output dip_in, load_pulse, run_pulse, step_mode, exec_ready,
    input  instr, instr_valid, pc, load_addr, halted
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_fetch : program memory loader and single-issue fetch sequencer  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module instr_fetch #(
  parameter int         ADDR_W  = 4,
  parameter logic [3:0] HALT_OP = 4'b1111
) (
  input  wire logic       clk,
  input  wire logic       rst,
  instr_fetch_if.master   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [7:0]        instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              halted_q, halted_d;
  logic              mem_we;
  logic [7:0]        fetch_word;

  // Program store: deliberately left out of reset so a reset keeps the program.
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr_q] <= bus.dip_in;
    end
  end

  assign fetch_word = mem_q[pc_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      load_addr_q <= '0;
      instr_q     <= 8'h00;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      load_addr_q <= load_addr_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_addr_d = load_addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    mem_we      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A load in the same cycle as a run wins; the run is dropped.
        if (bus.load_pulse) begin
          mem_we      = ~rst;
          load_addr_d = load_addr_q + ADDR_W'(1);
        end else if (bus.run_pulse) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        instr_d = fetch_word;
        if (fetch_word[3:0] == HALT_OP) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          valid_d = 1'b1;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (valid_q && bus.exec_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = bus.step_mode ? S_PAUSE : S_FETCH;
        end
      end

      S_PAUSE: begin
        if (bus.run_pulse) begin
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        // The pulse that leaves HALT is consumed here and never writes memory.
        if (bus.run_pulse || bus.load_pulse) begin
          halted_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.load_addr   = load_addr_q;
  assign bus.halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_fetch : scoreboard bench for instr_fetch                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [7:0] sb_q[$];

  instr_fetch_if #(.ADDR_W(4)) bus ();

  instr_fetch #(.ADDR_W(4), .HALT_OP(4'b1111)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    bus.dip_in     = d;
    bus.load_pulse = 1'b1;
    tick();
    bus.load_pulse = 1'b0;
  endtask

  task automatic do_run();
    bus.run_pulse = 1'b1;
    tick();
    bus.run_pulse = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!bus.halted && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.halted), 32'd1);
  endtask

  // Transfers are visible at the negedge before the edge that completes them.
  always @(negedge clk) begin
    if (!rst && bus.instr_valid && bus.exec_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_extra", 32'(sb_q.size()), 32'd1);
      end else begin
        chk("sb_instr", 32'(bus.instr), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    logic [3:0] a;
    bus.dip_in     = 8'h00;
    bus.load_pulse = 1'b0;
    bus.run_pulse  = 1'b0;
    bus.step_mode  = 1'b0;
    bus.exec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc",     32'(bus.pc),          32'd0);
    chk("rst_laddr",  32'(bus.load_addr),   32'd0);
    chk("rst_instr",  32'(bus.instr),       32'h00);
    chk("rst_valid",  32'(bus.instr_valid), 32'd0);
    chk("rst_halted", 32'(bus.halted),      32'd0);
    rst = 1'b0;
    tick();

    // Load + run in the same cycle: load executes, run dropped.
    bus.dip_in     = 8'h51;
    bus.load_pulse = 1'b1;
    bus.run_pulse  = 1'b1;
    tick();
    bus.load_pulse = 1'b0;
    bus.run_pulse  = 1'b0;
    chk("coll_laddr", 32'(bus.load_addr), 32'd1);
    tick();
    tick();
    chk("coll_valid", 32'(bus.instr_valid), 32'd0);
    do_load(8'h61);
    do_load(8'h0F);
    chk("load_laddr", 32'(bus.load_addr), 32'd3);

    // Free run
    bus.exec_ready = 1'b1;
    sb_q.push_back(8'h51);
    sb_q.push_back(8'h61);
    do_run();
    chk("fr_n1_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("fr_n2_valid", 32'(bus.instr_valid), 32'd1);
    chk("fr_n2_instr", 32'(bus.instr),       32'h51);
    tick();
    chk("fr_n3_pc",    32'(bus.pc),          32'd1);
    tick();
    chk("fr_n4_instr", 32'(bus.instr),       32'h61);
    chk("fr_n4_valid", 32'(bus.instr_valid), 32'd1);
    tick();
    tick();
    chk("fr_halted",   32'(bus.halted),      32'd1);
    chk("fr_halt_pc",  32'(bus.pc),          32'd2);
    chk("fr_halt_vld", 32'(bus.instr_valid), 32'd0);
    tick();
    chk("fr_sb_empty", 32'(sb_q.size()),     32'd0);

    // Load pulse leaves HALT without writing or advancing load_addr.
    do_load(8'hAA);
    chk("hlt_exit",  32'(bus.halted),    32'd0);
    chk("hlt_laddr", 32'(bus.load_addr), 32'd3);

    // 16 more loads wrap load_addr back to 3; mem[0..2] rewritten unchanged.
    for (int i = 0; i < 16; i++) begin
      a = 4'(3 + i);
      case (a)
        4'd0:    do_load(8'h51);
        4'd1:    do_load(8'h61);
        4'd2:    do_load(8'h0F);
        default: do_load({a, 4'h3});
      endcase
    end
    chk("wrap_laddr", 32'(bus.load_addr), 32'd3);

    // Backpressure
    bus.exec_ready = 1'b0;
    sb_q.push_back(8'h51);
    do_run();
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.run_pulse = 1'b1;
      tick();
      bus.run_pulse = 1'b0;
      chk("bp_valid", 32'(bus.instr_valid), 32'd1);
      chk("bp_instr", 32'(bus.instr),       32'h51);
      chk("bp_pc",    32'(bus.pc),          32'd0);
    end
    sb_q.push_back(8'h61);
    bus.exec_ready = 1'b1;
    tick();
    chk("bp_pc_inc", 32'(bus.pc),          32'd1);
    chk("bp_vld_lo", 32'(bus.instr_valid), 32'd0);
    wait_halt("bp_halt");
    chk("bp_halt_pc", 32'(bus.pc), 32'd2);
    do_run();
    chk("bp_exit", 32'(bus.halted), 32'd0);

    // Step mode
    bus.step_mode = 1'b1;
    sb_q.push_back(8'h51);
    do_run();
    tick();
    chk("st_valid1", 32'(bus.instr_valid), 32'd1);
    tick();
    repeat (3) tick();
    chk("st_park_vld", 32'(bus.instr_valid), 32'd0);
    chk("st_park_pc",  32'(bus.pc),          32'd1);
    do_load(8'hEE);
    chk("st_pause_ld", 32'(bus.load_addr), 32'd3);
    repeat (2) tick();
    chk("st_park_vld2", 32'(bus.instr_valid), 32'd0);
    sb_q.push_back(8'h61);
    do_run();
    tick();
    chk("st_instr2", 32'(bus.instr), 32'h61);
    tick();
    chk("st_pc2", 32'(bus.pc), 32'd2);
    do_run();
    wait_halt("st_halt");
    do_run();
    bus.step_mode = 1'b0;

    // Reset during ISSUE
    bus.exec_ready = 1'b0;
    do_run();
    tick();
    chk("rs_valid_pre", 32'(bus.instr_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_valid",  32'(bus.instr_valid), 32'd0);
    chk("rs_instr",  32'(bus.instr),       32'h00);
    chk("rs_pc",     32'(bus.pc),          32'd0);
    chk("rs_laddr",  32'(bus.load_addr),   32'd0);
    chk("rs_halted", 32'(bus.halted),      32'd0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();

    // Readback: program must survive the reset.
    bus.exec_ready = 1'b1;
    sb_q.push_back(8'h51);
    sb_q.push_back(8'h61);
    do_run();
    wait_halt("rb_halt");
    chk("rb_pc", 32'(bus.pc), 32'd2);
    tick();
    chk("rb_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, program-memory address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter HALT_OP, default 4'b1111, opcode field value that stops execution.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 dip_in  input  8  instruction word to load ({src[7:6], dst[5:4], opcode[3:0]}).
REQ-006 load_pulse  input  1  one-cycle debounced pulse; write dip_in into program memory.
REQ-007 run_pulse  input  1  one-cycle debounced pulse; start, resume or step execution.
REQ-008 step_mode  input  1  1 = pause after every issued instruction; 0 = free-run.
REQ-009 exec_ready  input  1  downstream execute stage can accept an instruction this cycle.
REQ-010 instr  output  8  instruction presented to the execute stage.
REQ-011 instr_valid  output  1  instr is valid; a transfer occurs when instr_valid and exec_ready are both 1.
REQ-012 pc  output  ADDR_W  address of the current or next instruction.
REQ-013 load_addr  output  ADDR_W  next program-memory write address.
REQ-014 halted  output  1  HALT_OP fetched; execution stopped.

Function
REQ-015 SHALL contain a 2^ADDR_W x 8 program memory that reset does not clear.
REQ-016 SHALL implement the states IDLE, FETCH, ISSUE, PAUSE and HALT, with the state encoding registered.
REQ-017 In IDLE, a load_pulse SHALL write dip_in to mem[load_addr] and increment load_addr modulo 2^ADDR_W (max wraps to 0).
REQ-018 In IDLE, a run_pulse SHALL set pc to 0 and move to FETCH; if load_pulse and run_pulse arrive in the same cycle, the load SHALL execute and the run SHALL be ignored.
REQ-019 FETCH SHALL last one cycle and register mem[pc] into instr; if mem[pc][3:0]==HALT_OP, the next state SHALL be HALT with instr_valid 0, otherwise ISSUE with instr_valid 1.
REQ-020 In ISSUE, instr and instr_valid SHALL stay stable until a transfer occurs; there SHALL be no timeout.
REQ-021 On a transfer, instr_valid SHALL deassert the next cycle and pc SHALL increment modulo 2^ADDR_W, with execution continuing from 0 after wrap.
REQ-022 After a transfer, the next state SHALL be PAUSE if step_mode=1, otherwise FETCH; step_mode SHALL be sampled in the transfer cycle.
REQ-023 In PAUSE, a run_pulse SHALL move to FETCH, and a load_pulse SHALL be ignored.
REQ-024 In HALT, halted SHALL be 1 and pc SHALL hold the halt address; a run_pulse or load_pulse SHALL return to IDLE with halted cleared, and no memory write SHALL occur for that pulse.
REQ-025 Outside IDLE, load_pulse SHALL never write memory or change load_addr.
REQ-026 Latency: run_pulse in cycle N -> FETCH in N+1 -> instr_valid=1 in N+2; in free-run with exec_ready held at 1, throughput SHALL be one instruction per 2 cycles.
REQ-027 A run_pulse received while in FETCH or ISSUE SHALL be ignored.

Reset
REQ-028 While rst=1, asynchronously: state=IDLE, pc=0, load_addr=0, instr=8'h00, instr_valid=0, halted=0.
REQ-029 Reset asserted mid-ISSUE SHALL drop instr_valid immediately and cancel the transfer; the memory contents SHALL be preserved.

Verification
REQ-030 Load test: apply load_pulse with dip 8'h51, 8'h61, 8'h0F -> mem[0..2]=51,61,0F and load_addr=3; after 16 more loads, load_addr wraps to 3.
REQ-031 Free-run test: step_mode=0, exec_ready=1, run_pulse -> instr 8'h51 (cycle N+2), then 8'h61 (N+4), then halted=1 with pc=2 and instr_valid never high for 8'h0F.
REQ-032 Backpressure test: exec_ready=0 for 5 cycles during ISSUE -> instr=8'h51 held stable with instr_valid=1 and pc=0; exec_ready=1 -> pc=1 the next cycle.
REQ-033 Step test: step_mode=1 -> one transfer per run_pulse, with the block parked in PAUSE between pulses and instr_valid=0.
REQ-034 Collision/reset test: simultaneous load_pulse+run_pulse in IDLE -> memory written and state stays IDLE; rst during ISSUE -> all outputs at reset values in the same cycle, and the memory is unchanged on readback.
